// File: rtl/bcd_serial_adder.sv
// -----------------------------------------------------------------------------
// bcd_serial_adder
//
// Digit-serial packed-BCD adder/subtractor. One BCD digit is processed per
// clock, least-significant digit first. Subtraction adds the nine's complement
// of b with a carry-in of 1; a missing final carry means the result is
// negative, and a second serial pass (NEG) turns the held ten's-complement
// value back into a magnitude.
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   operation request, sampled only while idle
//   sub       in   0: a+b, 1: a-b (sampled with start)
//   a, b      in   packed BCD operands, digit 0 in bits [3:0]
//   sum       out  packed BCD result, top digit holds the add carry
//   negative  out  subtraction result below zero (sum is the magnitude)
//   error     out  an operand digit was greater than 9 (sum forced to 0)
//   valid     out  one-cycle pulse when sum/negative/error are updated
//   busy      out  high whenever the block is not idle
// -----------------------------------------------------------------------------
module bcd_serial_adder #(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic [4*DIGITS+3:0] sum,
  output logic                negative,
  output logic                error,
  output logic                valid,
  output logic                busy
);

  localparam int         W        = 4 * DIGITS;
  localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  // One decimal digit step: x + y + cin with decimal adjust.
  // Returns {carry_out, digit}. Out-of-range inputs still produce a
  // deterministic value; such results are discarded through the error path.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                               input logic [3:0] y,
                                               input logic       cin);
    logic [4:0] raw;
    raw = {1'b0, x} + {1'b0, y} + {4'd0, cin};
    if (raw > 5'd9) begin
      bcd_digit_add = {1'b1, 4'(raw - 5'd10)};
    end else begin
      bcd_digit_add = {1'b0, raw[3:0]};
    end
  endfunction

  // Registered state
  state_t         state_q,    state_d;
  logic [W-1:0]   a_q,        a_d;        // shifts right one digit per CALC step
  logic [W-1:0]   b_q,        b_d;
  logic           sub_q,      sub_d;
  logic           carry_q,    carry_d;
  logic           err_q,      err_d;      // sticky bad-digit flag of the current op
  logic [3:0]     idx_q,      idx_d;
  logic [W-1:0]   res_q,      res_d;      // result digits shift in from the top
  logic [W+3:0]   sum_q,      sum_d;
  logic           negative_q, negative_d;
  logic           error_q,    error_d;
  logic           valid_q,    valid_d;
  logic           busy_q,     busy_d;

  // Combinational helpers
  logic [3:0]     b_digit_s;
  logic [4:0]     calc_digit_s;
  logic [4:0]     neg_digit_s;
  logic [W-1:0]   calc_res_s;
  logic [W-1:0]   neg_res_s;
  logic           digit_bad_s;
  logic           err_now_s;
  logic           last_digit_s;
  logic           load_s;
  logic           load_err_s;
  logic           load_neg_s;
  logic [W+3:0]   load_sum_s;

  // Per-digit arithmetic for the CALC and NEG passes.
  always_comb begin
    b_digit_s    = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    calc_digit_s = bcd_digit_add(a_q[3:0], b_digit_s, carry_q);
    neg_digit_s  = bcd_digit_add(4'd9 - res_q[3:0], 4'd0, carry_q);
    digit_bad_s  = (a_q[3:0] > 4'd9) || (b_q[3:0] > 4'd9);
    err_now_s    = err_q | digit_bad_s;
    last_digit_s = (idx_q == LAST_IDX);
  end

  // Shift the new digit in at the top of the result register; after DIGITS
  // steps digit 0 has arrived at bits [3:0].
  if (DIGITS == 1) begin : g_shift_one
    assign calc_res_s = calc_digit_s[3:0];
    assign neg_res_s  = neg_digit_s[3:0];
  end else begin : g_shift_multi
    assign calc_res_s = {calc_digit_s[3:0], res_q[W-1:4]};
    assign neg_res_s  = {neg_digit_s[3:0], res_q[W-1:4]};
  end

  // Next-state and next-output computation.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    carry_d    = carry_q;
    err_d      = err_q;
    idx_d      = idx_q;
    res_d      = res_q;
    load_s     = 1'b0;
    load_err_s = 1'b0;
    load_neg_s = 1'b0;
    load_sum_s = {(W+4){1'b0}};

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub;              // the +1 of the ten's complement of b
          err_d   = 1'b0;
          idx_d   = 4'd0;
          res_d   = {W{1'b0}};
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        a_d     = a_q >> 3'd4;
        b_d     = b_q >> 3'd4;
        res_d   = calc_res_s;
        carry_d = calc_digit_s[4];
        err_d   = err_now_s;
        if (last_digit_s) begin
          if (!sub_q) begin
            state_d    = DONE;
            load_s     = 1'b1;
            load_err_s = err_now_s;
            load_sum_s = {3'b000, calc_digit_s[4], calc_res_s};
          end else if (calc_digit_s[4]) begin
            // a >= b: the end-around carry is simply dropped
            state_d    = DONE;
            load_s     = 1'b1;
            load_err_s = err_now_s;
            load_sum_s = {4'd0, calc_res_s};
          end else begin
            // a < b: the held value is the ten's complement of |a-b|
            state_d = NEG;
            idx_d   = 4'd0;
            carry_d = 1'b1;
          end
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      NEG: begin
        res_d   = neg_res_s;
        carry_d = neg_digit_s[4];
        if (last_digit_s) begin
          state_d    = DONE;
          load_s     = 1'b1;
          load_err_s = err_q;
          load_neg_s = 1'b1;
          load_sum_s = {4'd0, neg_res_s};
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Result outputs change only on entry to DONE.
    if (load_s) begin
      if (load_err_s) begin
        sum_d      = {(W+4){1'b0}};
        negative_d = 1'b0;
        error_d    = 1'b1;
      end else begin
        sum_d      = load_sum_s;
        negative_d = load_neg_s;
        error_d    = 1'b0;
      end
    end else begin
      sum_d      = sum_q;
      negative_d = negative_q;
      error_d    = error_q;
    end

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      a_q        <= {W{1'b0}};
      b_q        <= {W{1'b0}};
      sub_q      <= 1'b0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= 4'd0;
      res_q      <= {W{1'b0}};
      sum_q      <= {(W+4){1'b0}};
      negative_q <= 1'b0;
      error_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      carry_q    <= carry_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      res_q      <= res_d;
      sum_q      <= sum_d;
      negative_q <= negative_d;
      error_q    <= error_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign sum      = sum_q;
  assign negative = negative_q;
  assign error    = error_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bcd_serial_adder
//
// Self-checking bench for bcd_serial_adder with DIGITS=3. A behavioural model
// computes results with integer arithmetic and tracks how many cycles each
// operation keeps the block busy; a compare process checks every DUT output
// against it on each falling edge. Directed operations additionally check
// hand-computed literal results and latencies.
// -----------------------------------------------------------------------------
module tb_bcd_serial_adder;

  localparam int D = 3;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          start    = 1'b0;
  logic          sub      = 1'b0;
  logic [11:0]   a        = 12'h000;
  logic [11:0]   b        = 12'h000;
  logic [15:0]   sum;
  logic          negative;
  logic          error;
  logic          valid;
  logic          busy;

  int checks = 0;
  int errors = 0;

  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .sum      (sum),
    .negative (negative),
    .error    (error),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [15:0] s;
    logic        n;
    logic        e;
  } res_t;

  function automatic int bcd2int(input logic [11:0] v);
    int r = 0;
    logic [11:0] t = v;
    for (int i = 0; i < 3; i++) begin
      r = r * 10 + int'(t[11:8]);
      t = t << 4;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [11:0] v);
    logic bad = 1'b0;
    logic [11:0] t = v;
    for (int i = 0; i < 3; i++) begin
      if (t[3:0] > 4'd9) bad = 1'b1;
      t = t >> 4;
    end
    return bad;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r = 16'h0000;
    int m = n;
    for (int i = 0; i < 4; i++) begin
      r = {4'(m % 10), r[15:4]};
      m = m / 10;
    end
    return r;
  endfunction

  function automatic res_t model_op(input logic [11:0] ia, input logic [11:0] ib, input logic isub);
    res_t r;
    int x = bcd2int(ia);
    int y = bcd2int(ib);
    if (has_bad(ia) || has_bad(ib)) begin
      r.s = 16'h0000; r.n = 1'b0; r.e = 1'b1;
    end else if (!isub) begin
      r.s = int2bcd(x + y); r.n = 1'b0; r.e = 1'b0;
    end else if (x >= y) begin
      r.s = int2bcd(x - y); r.n = 1'b0; r.e = 1'b0;
    end else begin
      r.s = int2bcd(y - x); r.n = 1'b1; r.e = 1'b0;
    end
    return r;
  endfunction

  function automatic int op_lat(input logic [11:0] ia, input logic [11:0] ib, input logic isub);
    if (!has_bad(ia) && !has_bad(ib) && isub && (bcd2int(ia) < bcd2int(ib))) return 2 * D;
    return D;
  endfunction

  // m_cnt: cycles of busy remaining; valid is expected when it reads 1.
  int          m_cnt = 0;
  res_t        pend  = '0;
  logic [15:0] m_sum = 16'h0000;
  logic        m_neg = 1'b0;
  logic        m_err = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt <= 0;
      m_sum <= 16'h0000;
      m_neg <= 1'b0;
      m_err <= 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        pend  <= model_op(a, b, sub);
        m_cnt <= op_lat(a, b, sub) + 1;
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) begin
        m_sum <= pend.s;
        m_neg <= pend.n;
        m_err <= pend.e;
      end
    end
  end

  // Compare process: every output, every cycle, away from the rising edge.
  always @(negedge clk) begin
    check("cmp_sum",      32'(sum),      32'(m_sum));
    check("cmp_negative", 32'(negative), 32'(m_neg));
    check("cmp_error",    32'(error),    32'(m_err));
    check("cmp_valid",    32'(valid),    32'(m_cnt == 1));
    check("cmp_busy",     32'(busy),     32'(m_cnt != 0));
  end

  // ---------------- directed helpers ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input string nm, input logic [11:0] ia, input logic [11:0] ib,
                        input logic isub, input logic [15:0] xs, input logic xn,
                        input logic xe, input int xlat);
    int  k    = 0;
    bit  seen = 1'b0;
    wait_idle();
    start = 1'b1; a = ia; b = ib; sub = isub;
    @(negedge clk);
    // scramble inputs after acceptance; the result must not change
    start = 1'b0; a = 12'($urandom); b = 12'($urandom); sub = ~isub;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (valid) begin
        seen = 1'b1;
        check({nm, "_latency"},  32'(k),        32'(xlat));
        check({nm, "_sum"},      32'(sum),      32'(xs));
        check({nm, "_negative"}, 32'(negative), 32'(xn));
        check({nm, "_error"},    32'(error),    32'(xe));
      end
    end
    check({nm, "_valid_seen"}, 32'(seen), 32'd1);
  endtask

  function automatic logic [11:0] rand_bcd();
    logic [11:0] v = 12'h000;
    for (int i = 0; i < 3; i++) v = {v[7:0], 4'($urandom_range(0, 9))};
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int nvalid;
    logic [15:0] cap_sum;

    #1 reset = 1'b0;
    #11;
    check("reset_sum",   32'(sum),   32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy",  32'(busy),  32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    run_op("add_123_456", 12'h123, 12'h456, 1'b0, 16'h0579, 1'b0, 1'b0, 3);
    run_op("add_999_999", 12'h999, 12'h999, 1'b0, 16'h1998, 1'b0, 1'b0, 3);
    run_op("sub_456_123", 12'h456, 12'h123, 1'b1, 16'h0333, 1'b0, 1'b0, 3);
    run_op("sub_123_456", 12'h123, 12'h456, 1'b1, 16'h0333, 1'b1, 1'b0, 6);
    run_op("sub_500_500", 12'h500, 12'h500, 1'b1, 16'h0000, 1'b0, 1'b0, 3);
    run_op("sub_000_999", 12'h000, 12'h999, 1'b1, 16'h0999, 1'b1, 1'b0, 6);
    run_op("err_1A3_001", 12'h1A3, 12'h001, 1'b0, 16'h0000, 1'b0, 1'b1, 3);

    // start pulsed again during CALC must be ignored
    wait_idle();
    start = 1'b1; a = 12'h123; b = 12'h456; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 12'h999; b = 12'h999;
    @(negedge clk);
    start = 1'b0;
    nvalid  = 0;
    cap_sum = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      if (valid) begin
        nvalid++;
        cap_sum = sum;
      end
      @(negedge clk);
    end
    check("restart_valid_count", 32'(nvalid), 32'd1);
    check("restart_sum",         32'(cap_sum), 32'h0579);

    // reset two edges after start: abort, outputs cleared at once
    wait_idle();
    start = 1'b1; a = 12'h321; b = 12'h111; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_sum",   32'(sum),   32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_busy",  32'(busy),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    check("abort_no_valid", 32'(nvalid), 32'd0);
    run_op("after_reset", 12'h321, 12'h111, 1'b0, 16'h0432, 1'b0, 1'b0, 3);

    // randomized traffic, including start held high and inputs changing while busy
    wait_idle();
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 2) == 0);
      sub   = 1'($urandom_range(0, 1));
      a     = rand_bcd();
      b     = ($urandom_range(0, 9) == 0) ? a : rand_bcd();
      if (!sub && $urandom_range(0, 7) == 0) a[7:4] = 4'($urandom_range(10, 15));
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 The block SHALL have parameter DIGITS, default 3, legal range 1..8, giving the number of BCD digits per operand.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 The block SHALL have port sub, input, 1 bit: operation select, 0 = a+b, 1 = a-b; sampled with start.
REQ-006 The block SHALL have port a, input, 4*DIGITS bits: first operand, packed BCD, digit 0 in bits [3:0].
REQ-007 The block SHALL have port b, input, 4*DIGITS bits: second operand, packed BCD.
REQ-008 The block SHALL have port sum, output, 4*DIGITS+4 bits: packed BCD result; the top digit holds the add carry.
REQ-009 The block SHALL have port negative, output, 1 bit: subtraction result is below zero; sum then holds the magnitude.
REQ-010 The block SHALL have port error, output, 1 bit: an operand contained a digit greater than 9.
REQ-011 The block SHALL have port valid, output, 1 bit: one-cycle pulse, result outputs updated.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC, NEG and DONE.
REQ-014 In IDLE with start=1 at a clock edge, the block SHALL latch a, b and sub, clear the digit index, set carry-in to sub, and enter CALC.
REQ-015 In CALC, the block SHALL process one digit per edge, least-significant first.
- add: digit = a_i + b_i + carry; if the digit exceeds 9, subtract 10 and carry 1.
- sub: use the nine's complement of b_i (9 - b_i) in place of b_i.
REQ-016 After the edge that processes digit DIGITS-1, the next state SHALL be as follows.
- add: DONE; sum top digit = final carry (0 or 1).
- sub, final carry 1: DONE; top digit 0, negative=0.
- sub, final carry 0: NEG; digit index cleared, borrow-in 1.
REQ-017 In NEG, the block SHALL convert the held result to its ten's complement, one digit per edge (9 - d_i + carry, with the same decimal adjust), then enter DONE with negative=1 and top digit 0.
REQ-018 DONE SHALL last exactly one cycle with valid=1, then return to IDLE.
REQ-019 Latency from the start-sampling edge to valid high SHALL be:
- DIGITS edges for add and non-negative sub;
- 2*DIGITS edges for negative sub.
REQ-020 If any latched digit of a or b exceeds 9, the block SHALL run normal timing but present, in DONE, error=1, sum=0 and negative=0.
REQ-021 sum, negative and error SHALL be updated only on entry to DONE and SHALL hold until the next DONE.
REQ-022 start in CALC, NEG or DONE SHALL be ignored with no queuing.
- Minimum start-to-start spacing: DIGITS+2 edges for add.
- start held high is re-accepted on the first IDLE edge.
REQ-023 Input changes on a, b or sub after the accepting edge SHALL NOT affect the result in progress.
REQ-024 sum SHALL equal a+b exactly for all valid operands; maximum value 2*(10^DIGITS - 1), e.g. 1998 for DIGITS=3.

Reset
REQ-025 While reset=0, the block SHALL force state=IDLE, sum=0, negative=0, error=0, valid=0, busy=0, and clear all internal registers, independent of clk.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no valid pulse; the first start after release SHALL be processed normally.

Verification (DIGITS=3)
REQ-027 The bench SHALL cover each of the following scenarios.
- start, sub=0, a=0x123, b=0x456 -> valid 3 edges later, sum=0x0579, negative=0, error=0.
- sub=0, a=0x999, b=0x999 -> sum=0x1998 (carry into the top digit).
- sub=1, a=0x456, b=0x123 -> valid after 3 edges, sum=0x0333, negative=0.
- sub=1, a=0x123, b=0x456 -> valid after 6 edges, sum=0x0333, negative=1; also a=b=0x500 -> sum=0x0000, negative=0.
- a=0x1A3, b=0x001 -> valid after 3 edges, error=1, sum=0.
- start pulsed again during CALC -> ignored, exactly one valid.
- reset pulled low 2 edges after start -> outputs 0 immediately, no valid; the next op is correct.
